// File: rtl/sig_control_param.sv
// Highway/country-road signal controller with programmable phase timing.
// Optional pedestrian request path enabled by SIG_CONTROL_PED_REQ_EN.
module sig_control_param #(
    parameter int HWY_MIN_GREEN   = 8,
    parameter int YELLOW_T        = 3,
    parameter int ALLRED_T        = 2,
    parameter int CNTRY_MIN_GREEN = 4,
    parameter int CNTRY_MAX_GREEN = 10
) (
    input  logic       clock,
    input  logic       clear,
    input  logic       X,
`ifdef SIG_CONTROL_PED_REQ_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [1:0] hwy,
    output logic [1:0] cntry,
    output logic [2:0] state
);

    localparam int MAX_A = (HWY_MIN_GREEN > YELLOW_T) ? HWY_MIN_GREEN : YELLOW_T;
    localparam int MAX_B = (MAX_A > ALLRED_T) ? MAX_A : ALLRED_T;
    localparam int MAX_C = (MAX_B > CNTRY_MIN_GREEN) ? MAX_B : CNTRY_MIN_GREEN;
    localparam int MAX_P = (MAX_C > CNTRY_MAX_GREEN) ? MAX_C : CNTRY_MAX_GREEN;
    localparam int TW    = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] T_HMG  = TW'(HWY_MIN_GREEN - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] T_AR   = TW'(ALLRED_T - 1);
    localparam logic [TW-1:0] T_CMIN = TW'(CNTRY_MIN_GREEN - 1);
    localparam logic [TW-1:0] T_CMAX = TW'(CNTRY_MAX_GREEN - 1);

    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } st_t;

    st_t           st_q;
    st_t           st_d;
    logic [TW-1:0] timer;
    logic          req;

    assign state = st_q;

`ifdef SIG_CONTROL_PED_REQ_EN
    logic ped_pend;
    logic ent_cg;

    assign req    = X | ped_pend;
    assign ent_cg = (st_d == S3) && (st_q != S3);

    // Sticky pedestrian request; walk reflects the reason S3 was entered.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            ped_pend <= 1'b0;
            walk     <= 1'b0;
        end else begin
            ped_pend <= ped_req | (ped_pend & ~ent_cg);
            if (st_d != S3)
                walk <= 1'b0;
            else if (ent_cg)
                walk <= ped_pend;
        end
    end
`else
    assign req = X;
`endif

    function automatic logic [1:0] hwy_of(input st_t s);
        case (s)
            S0:      hwy_of = GREEN;
            S1:      hwy_of = YELLOW;
            default: hwy_of = RED;
        endcase
    endfunction

    function automatic logic [1:0] cntry_of(input st_t s);
        case (s)
            S3:      cntry_of = GREEN;
            S4:      cntry_of = YELLOW;
            default: cntry_of = RED;
        endcase
    endfunction

    // Next-state selection from the phase timer and the request input.
    always_comb begin
        st_d = S0;
        case (st_q)
            S0: st_d = (req && timer == T_HMG) ? S1 : S0;
            S1: st_d = (timer == T_YEL) ? S2 : S1;
            S2: st_d = (timer == T_AR) ? S3 : S2;
            S3: st_d = ((!X && timer >= T_CMIN) || timer == T_CMAX) ? S4 : S3;
            S4: st_d = (timer == T_YEL) ? S5 : S4;
            S5: st_d = (timer == T_AR) ? S0 : S5;
            default: st_d = S0;
        endcase
    end

    // State, phase timer and lamps all update together on the edge.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            st_q  <= S0;
            timer <= '0;
            hwy   <= GREEN;
            cntry <= RED;
        end else begin
            st_q  <= st_d;
            hwy   <= hwy_of(st_d);
            cntry <= cntry_of(st_d);
            if (st_d != st_q)
                timer <= '0;
            else if (st_q == S0 && timer == T_HMG)
                timer <= timer;
            else
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_sig_control_param.sv
// Directed bench for sig_control_param: reset, phase lengths,
// max/min green, async clear mid-phase, and X toggling.
module tb_sig_control_param;

    localparam int HMG  = 8;
    localparam int YEL  = 3;
    localparam int AR   = 2;
    localparam int CMIN = 4;
    localparam int CMAX = 10;

    logic       clock;
    logic       clear;
    logic       X;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic [2:0] state;
`ifdef SIG_CONTROL_PED_REQ_EN
    logic       ped_req;
    logic       walk;
`endif

    int total;
    int bad;

    sig_control_param #(
        .HWY_MIN_GREEN   (HMG),
        .YELLOW_T        (YEL),
        .ALLRED_T        (AR),
        .CNTRY_MIN_GREEN (CMIN),
        .CNTRY_MAX_GREEN (CMAX)
    ) dut (
        .clock   (clock),
        .clear   (clear),
        .X       (X),
`ifdef SIG_CONTROL_PED_REQ_EN
        .ped_req (ped_req),
        .walk    (walk),
`endif
        .hwy     (hwy),
        .cntry   (cntry),
        .state   (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    function automatic int hwy_exp(input int s);
        case (s)
            0:       return 2;
            1:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cntry_exp(input int s);
        case (s)
            3:       return 2;
            4:       return 1;
            default: return 0;
        endcase
    endfunction

    // Called at the first negedge of a phase; returns at the first
    // negedge of the following phase.
    task automatic expect_len(input string tag, input int st,
                              input int len, input bit tog);
        int n;
        check({tag, "_st"}, int'(state), st);
        check({tag, "_hwy"}, int'(hwy), hwy_exp(st));
        check({tag, "_cntry"}, int'(cntry), cntry_exp(st));
        n = 0;
        while (int'(state) == st && n < 50) begin
            if (tog) X = ~X;
            @(negedge clock);
            n++;
        end
        check({tag, "_len"}, n, len);
    endtask

    task automatic async_clear(input string tag);
        #2 clear = 1'b1;
        #1;
        check({tag, "_st"}, int'(state), 0);
        check({tag, "_hwy"}, int'(hwy), 2);
        check({tag, "_cntry"}, int'(cntry), 0);
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        X     = 1'b0;
        clear = 1'b1;
`ifdef SIG_CONTROL_PED_REQ_EN
        ped_req = 1'b0;
`endif
        repeat (5) @(negedge clock);
        check("rst_st", int'(state), 0);
        check("rst_hwy", int'(hwy), 2);
        check("rst_cntry", int'(cntry), 0);
        clear = 1'b0;

        // Idle with no car: highway green forever.
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            check("idle_st", int'(state), 0);
            check("idle_hwy", int'(hwy), 2);
            check("idle_cntry", int'(cntry), 0);
        end

        // Basic request with saturated timer: yields on the next edge.
        X = 1'b1;
        @(negedge clock);
        expect_len("b_hy", 1, YEL, 1'b0);
        expect_len("b_ar1", 2, AR, 1'b0);
        check("b_cg_st", int'(state), 3);
        check("b_cg_cntry", int'(cntry), 2);
        check("b_cg_hwy", int'(hwy), 0);
        repeat (5) @(negedge clock);
        check("b_cg_hold", int'(state), 3);
        X = 1'b0;
        @(negedge clock);
        expect_len("b_cy", 4, YEL, 1'b0);
        expect_len("b_ar2", 5, AR, 1'b0);

        // Max green guard and fairness with X held high.
        X = 1'b1;
        expect_len("m_hg", 0, HMG, 1'b0);
        expect_len("m_hy", 1, YEL, 1'b0);
        expect_len("m_ar1", 2, AR, 1'b0);
        expect_len("m_cg", 3, CMAX, 1'b0);
        expect_len("m_cy", 4, YEL, 1'b0);
        expect_len("m_ar2", 5, AR, 1'b0);
        expect_len("m_hg2", 0, HMG, 1'b0);
        expect_len("m_hy2", 1, YEL, 1'b0);

        // Async clear in S2, then min green from reset with X=1.
        async_clear("c_ar1");
        expect_len("c_hg", 0, HMG, 1'b0);
        expect_len("c_hy", 1, YEL, 1'b0);
        expect_len("c_ar1b", 2, AR, 1'b0);
        expect_len("c_cg", 3, CMAX, 1'b0);
        async_clear("c_cy");
        X = 1'b1;

        // Toggled X in yellow, single X pulse at start of country green.
        expect_len("t_hg", 0, HMG, 1'b0);
        expect_len("t_hy", 1, YEL, 1'b1);
        X = 1'b0;
        expect_len("t_ar1", 2, AR, 1'b0);
        check("t_cg_st", int'(state), 3);
        X = 1'b1;
        @(negedge clock);
        X = 1'b0;
        expect_len("t_cg", 3, CMIN - 1, 1'b0);
        expect_len("t_cy", 4, YEL, 1'b1);
        X = 1'b0;
        expect_len("t_ar2", 5, AR, 1'b0);
        repeat (20) @(negedge clock);
        check("t_idle", int'(state), 0);

`ifdef SIG_CONTROL_PED_REQ_EN
        begin
            int n;
            int nw;
            ped_req = 1'b1;
            @(negedge clock);
            ped_req = 1'b0;
            check("p_s0", int'(state), 0);
            @(negedge clock);
            expect_len("p_hy", 1, YEL, 1'b0);
            expect_len("p_ar1", 2, AR, 1'b0);
            check("p_walk0", int'(walk), 1);
            n  = 0;
            nw = 0;
            while (int'(state) == 3 && n < 50) begin
                if (walk) nw++;
                ped_req = (n == 1);
                @(negedge clock);
                n++;
            end
            ped_req = 1'b0;
            check("p_cg_len", n, CMIN);
            check("p_walk_len", nw, CMIN);
            check("p_walk_off", int'(walk), 0);
            expect_len("p_cy", 4, YEL, 1'b0);
            expect_len("p_ar2", 5, AR, 1'b0);
            expect_len("p_hg", 0, HMG, 1'b0);
            expect_len("p_hy2", 1, YEL, 1'b0);
            expect_len("p_ar1b", 2, AR, 1'b0);
            check("p_walk2", int'(walk), 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
